uart_rx_pfifo: RTL and testbench

Parametrised successor to the current UART receive path. It is a 16x-oversampled receiver with:
- runtime baud divisor
- selectable parity (none/even/odd)
- configurable data and stop length
- break detection
- receive FIFO that stores each data word with its own parity and framing error flags, plus a sticky overrun flag

It sits between the pad-side rx line and the bus-side register interface of uart_top.

---
 rtl/uart_rx_pfifo_if.sv | 31 +++
 rtl/uart_rx_pfifo.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_pfifo.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pfifo_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_pfifo_if
// Brief    : Bus-side read interface of the UART receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_pfifo_if #(
    parameter int DBIT = 8
);
    logic            rd_uart;
    logic            clr_overrun;
    logic [DBIT-1:0] r_data;
    logic            r_perr;
    logic            r_ferr;
    logic            rx_empty;
    logic            rx_full;
    logic            overrun;
    logic            brk;

    modport master (
        output rd_uart, clr_overrun,
        input  r_data, r_perr, r_ferr, rx_empty, rx_full, overrun, brk
    );

    modport slave (
        input  rd_uart, clr_overrun,
        output r_data, r_perr, r_ferr, rx_empty, rx_full, overrun, brk
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_pfifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_pfifo
// Brief    : 16x oversampled UART receiver with parity, break detection and
//            an error-tagged first-word fall-through receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_pfifo #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR_BIT = 11,
    parameter int FIFO_W   = 2
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic [DVSR_BIT-1:0] dvsr,
    input  wire logic [1:0]          par_mode,
    input  wire logic                rx,
    uart_rx_pfifo_if.slave           bus
);
    localparam int         c_DEPTH  = 2**FIFO_W;
    localparam int         c_W      = DBIT + 2;
    localparam logic [5:0] c_S_MID  = 6'd7;
    localparam logic [5:0] c_S_BIT  = 6'd15;
    localparam logic [5:0] c_S_STOP = 6'(SB_TICK - 1);
    localparam logic [3:0] c_N_LAST = 4'(DBIT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_t;

    logic                r_sync1, r_sync2;
    logic [DVSR_BIT-1:0] r_tcnt, r_dvsr_l;
    state_t              r_state;
    logic [5:0]          r_s;
    logic [3:0]          r_n;
    logic [DBIT-1:0]     r_shift;
    logic                r_pbit;
    logic [1:0]          r_par;
    logic                r_brk;

    logic [c_W-1:0]      r_mem [c_DEPTH];
    logic [FIFO_W-1:0]   r_wptr, r_rptr;
    logic                r_empty, r_full, r_overrun;

    logic                w_tick, w_par_en, w_stop_done, w_ferr, w_perr, w_break;
    logic                w_pop, w_wr, w_ovr_set;
    logic [FIFO_W-1:0]   w_wptr_inc, w_rptr_inc;
    logic [c_W-1:0]      w_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // >= rather than == so a divisor shrunk below the running count wraps at once
    assign w_tick = (r_tcnt >= r_dvsr_l);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcnt   <= '0;
            r_dvsr_l <= '0;
        end else begin
            if (r_state == S_IDLE)
                r_dvsr_l <= dvsr;
            r_tcnt <= w_tick ? '0 : r_tcnt + DVSR_BIT'(1);
        end
    end

    assign w_par_en    = r_par[0] ^ r_par[1];
    assign w_stop_done = (r_state == S_STOP) && w_tick && (r_s == c_S_STOP);
    assign w_ferr      = ~r_sync2;
    // Odd mode (10) expects the data+parity XOR to be 1, even mode expects 0
    assign w_perr      = w_par_en && ((^r_shift ^ r_pbit) != r_par[1]);
    assign w_break     = w_ferr && (r_shift == '0) && (!w_par_en || !r_pbit);
    assign w_wdata     = {w_perr, w_ferr, r_shift};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_pbit  <= 1'b0;
            r_par   <= 2'b00;
            r_brk   <= 1'b0;
        end else begin
            r_brk <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= S_START;
                        r_s     <= '0;
                        r_par   <= par_mode;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_s == c_S_MID) begin
                            r_s <= '0;
                            r_n <= '0;
                            r_state <= r_sync2 ? S_IDLE : S_DATA;
                        end else begin
                            r_s <= r_s + 6'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_s == c_S_BIT) begin
                            r_s     <= '0;
                            r_shift <= {r_sync2, r_shift[DBIT-1:1]};
                            r_n     <= r_n + 4'd1;
                            if (r_n == c_N_LAST)
                                r_state <= w_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_s <= r_s + 6'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        if (r_s == c_S_BIT) begin
                            r_s     <= '0;
                            r_pbit  <= r_sync2;
                            r_state <= S_STOP;
                        end else begin
                            r_s <= r_s + 6'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_s == c_S_STOP) begin
                            r_s <= '0;
                            if (w_break) begin
                                r_brk   <= 1'b1;
                                r_state <= S_BRK_WAIT;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_s <= r_s + 6'd1;
                        end
                    end
                end
                S_BRK_WAIT: begin
                    if (r_sync2)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_pop      = bus.rd_uart && !r_empty;
    assign w_wr       = w_stop_done && (!r_full || w_pop);
    assign w_ovr_set  = w_stop_done && r_full && !w_pop;
    assign w_wptr_inc = r_wptr + FIFO_W'(1);
    assign w_rptr_inc = r_rptr + FIFO_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_DEPTH; i++)
                r_mem[i] <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)
                r_mem[r_wptr] <= w_wdata;
            case ({w_wr, w_pop})
                2'b10: begin
                    r_wptr  <= w_wptr_inc;
                    r_empty <= 1'b0;
                    r_full  <= (w_wptr_inc == r_rptr);
                end
                2'b01: begin
                    r_rptr  <= w_rptr_inc;
                    r_full  <= 1'b0;
                    r_empty <= (w_rptr_inc == r_wptr);
                end
                2'b11: begin
                    r_wptr <= w_wptr_inc;
                    r_rptr <= w_rptr_inc;
                end
                default: ;
            endcase
            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (bus.clr_overrun)
                r_overrun <= 1'b0;
        end
    end

    assign bus.r_data   = r_mem[r_rptr][DBIT-1:0];
    assign bus.r_ferr   = r_mem[r_rptr][DBIT];
    assign bus.r_perr   = r_mem[r_rptr][DBIT+1];
    assign bus.rx_empty = r_empty;
    assign bus.rx_full  = r_full;
    assign bus.overrun  = r_overrun;
    assign bus.brk      = r_brk;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pfifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_pfifo
// Brief    : Self-checking bench: vector table, randomized frames against a
//            parity/framing model, and hand-written FIFO/break/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_pfifo;
    localparam int DBIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] dvsr;
    logic [1:0]  par_mode;
    logic        rx;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          brk_cnt = 0;

    uart_rx_pfifo_if #(.DBIT(DBIT)) bus ();

    uart_rx_pfifo #(
        .DBIT(DBIT), .SB_TICK(16), .DVSR_BIT(11), .FIFO_W(2)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .dvsr     (dvsr),
        .par_mode (par_mode),
        .rx       (rx),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.brk === 1'b1)
            brk_cnt <= brk_cnt + 1;

    typedef struct {
        logic [7:0] d;
        logic [1:0] pm;
        logic       pbit;
        logic       stop;
        logic [7:0] e_d;
        logic       e_perr;
        logic       e_ferr;
    } vec_t;

    vec_t vecs[6];

    function automatic int bclk();
        return 16 * (int'(dvsr) + 1);
    endfunction

    // Reference: parity over data+parity bit must be even (01) or odd (10)
    function automatic logic model_perr(logic [7:0] d, logic [1:0] pm, logic pbit);
        int ones;
        if (pm != 2'b01 && pm != 2'b10)
            return 1'b0;
        ones = $countones(d) + int'(pbit);
        return ((ones % 2) == 1) != (pm == 2'b10);
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold_rx(input logic v, input int clocks);
        rx = v;
        wait_clk(clocks);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic pbit,
                              input logic stop, input int stop_clks);
        hold_rx(1'b0, bclk());
        for (int i = 0; i < DBIT; i++)
            hold_rx(d[i], bclk());
        if (par_en)
            hold_rx(pbit, bclk());
        hold_rx(stop, stop_clks);
        rx = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic perr,
                             input logic ferr);
        check({tag, "_nonempty"}, 32'(bus.rx_empty), 32'd0);
        check({tag, "_data"}, 32'(bus.r_data), 32'(d));
        check({tag, "_perr"}, 32'(bus.r_perr), 32'(perr));
        check({tag, "_ferr"}, 32'(bus.r_ferr), 32'(ferr));
        bus.rd_uart = 1'b1;
        wait_clk(1);
        bus.rd_uart = 1'b0;
    endtask

    initial begin
        int t;
        int b0;
        logic [7:0] rd;
        logic [1:0] rpm;
        logic       rpb;

        vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 2'b01, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[2] = '{8'h03, 2'b01, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[3] = '{8'h03, 2'b10, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[4] = '{8'hC3, 2'b10, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0};
        vecs[5] = '{8'h5A, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};

        reset = 1'b0; rx = 1'b1; dvsr = 11'd3; par_mode = 2'b00;
        bus.rd_uart = 1'b0; bus.clr_overrun = 1'b0;
        wait_clk(3);
        check("rst_data",    32'(bus.r_data),   32'd0);
        check("rst_perr",    32'(bus.r_perr),   32'd0);
        check("rst_ferr",    32'(bus.r_ferr),   32'd0);
        check("rst_empty",   32'(bus.rx_empty), 32'd1);
        check("rst_full",    32'(bus.rx_full),  32'd0);
        check("rst_overrun", 32'(bus.overrun),  32'd0);
        check("rst_brk",     32'(bus.brk),      32'd0);
        reset = 1'b1;
        wait_clk(bclk());

        // Start edge to rx_empty falling should be about 9.5 bit times
        t = 0;
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1, bclk());
            begin
                while (bus.rx_empty && t < 1000) begin
                    wait_clk(1);
                    t++;
                end
            end
        join
        check("t1_latency", 32'(t >= 590 && t <= 640), 32'd1);
        pop_check("t1", 8'hA5, 1'b0, 1'b0);
        check("t1_empty_after_pop", 32'(bus.rx_empty), 32'd1);
        wait_clk(bclk());

        b0 = brk_cnt;
        for (int v = 0; v < 6; v++) begin
            par_mode = vecs[v].pm;
            send_frame(vecs[v].d, vecs[v].pm == 2'b01 || vecs[v].pm == 2'b10, vecs[v].pbit,
                       vecs[v].stop, vecs[v].stop ? bclk() : (bclk() * 5) / 8);
            wait_clk(2 * bclk());
            pop_check($sformatf("vec%0d", v), vecs[v].e_d, vecs[v].e_perr, vecs[v].e_ferr);
            check($sformatf("vec%0d_drained", v), 32'(bus.rx_empty), 32'd1);
        end
        check("vec_no_brk", 32'(brk_cnt - b0), 32'd0);
        par_mode = 2'b00;

        b0 = brk_cnt;
        hold_rx(1'b0, 20 * bclk());
        check("brk_pulses", 32'(brk_cnt - b0), 32'd1);
        pop_check("brk_word", 8'h00, 1'b0, 1'b1);
        check("brk_single_word", 32'(bus.rx_empty), 32'd1);
        hold_rx(1'b1, 2 * bclk());
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, bclk());
        wait_clk(bclk());
        pop_check("post_brk", 8'h33, 1'b0, 1'b0);
        check("post_brk_pulses", 32'(brk_cnt - b0), 32'd1);

        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b0, 1'b0, 1'b1, bclk());
            wait_clk(bclk());
            if (k == 3) check("ovf_not_full3", 32'(bus.rx_full), 32'd0);
            if (k == 4) begin
                check("ovf_full4", 32'(bus.rx_full), 32'd1);
                check("ovf_no_ovr4", 32'(bus.overrun), 32'd0);
            end
        end
        check("ovf_full5", 32'(bus.rx_full), 32'd1);
        check("ovf_ovr5", 32'(bus.overrun), 32'd1);
        for (int k = 1; k <= 4; k++)
            pop_check($sformatf("ovf_pop%0d", k), 8'(k), 1'b0, 1'b0);
        check("ovf_empty", 32'(bus.rx_empty), 32'd1);
        check("ovf_not_full", 32'(bus.rx_full), 32'd0);
        check("ovf_sticky", 32'(bus.overrun), 32'd1);
        bus.clr_overrun = 1'b1;
        wait_clk(1);
        bus.clr_overrun = 1'b0;
        check("ovf_cleared", 32'(bus.overrun), 32'd0);

        hold_rx(1'b0, 5 * (int'(dvsr) + 1));
        hold_rx(1'b1, 2 * bclk());
        check("glitch_no_push", 32'(bus.rx_empty), 32'd1);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, bclk());
        wait_clk(bclk());
        pop_check("post_glitch", 8'hC3, 1'b0, 1'b0);

        // Leave a word in the FIFO so the reset visibly clears storage
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, bclk());
        wait_clk(bclk());
        check("prerst_nonempty", 32'(bus.rx_empty), 32'd0);
        hold_rx(1'b0, bclk());
        hold_rx(1'b1, bclk());
        hold_rx(1'b0, bclk());
        hold_rx(1'b1, bclk());
        hold_rx(1'b1, bclk() / 2);
        reset = 1'b0;
        wait_clk(2);
        check("midrst_data",    32'(bus.r_data),   32'd0);
        check("midrst_perr",    32'(bus.r_perr),   32'd0);
        check("midrst_ferr",    32'(bus.r_ferr),   32'd0);
        check("midrst_empty",   32'(bus.rx_empty), 32'd1);
        check("midrst_full",    32'(bus.rx_full),  32'd0);
        check("midrst_overrun", 32'(bus.overrun),  32'd0);
        check("midrst_brk",     32'(bus.brk),      32'd0);
        rx = 1'b1;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(2 * bclk());
        check("postrst_empty", 32'(bus.rx_empty), 32'd1);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, bclk());
        wait_clk(bclk());
        pop_check("postrst", 8'h7E, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rd  = 8'($urandom_range(0, 255));
            rpm = 2'($urandom_range(0, 3));
            rpb = 1'($urandom_range(0, 1));
            dvsr = 11'($urandom_range(0, 2) * 2 + 1);
            par_mode = rpm;
            wait_clk(bclk());
            send_frame(rd, rpm == 2'b01 || rpm == 2'b10, rpb, 1'b1, bclk());
            wait_clk(bclk());
            pop_check($sformatf("rand%0d", i), rd, model_perr(rd, rpm, rpb), 1'b0);
        end
        dvsr = 11'd3;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
